fft_frame_sequencer: RTL
========================

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 Parameter FFT_LEN, default 64, SHALL set the samples per frame and the bins drained per frame (power of two, 8..1024).
REQ-002 Parameter WAIT_MAX, default 1023, SHALL set the timeout in clk cycles for each of the FLUSH and DETECT states.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port sample_valid, input, 1: one-cycle pulse marking a new MCU sample.
REQ-006 Port sample_in, input, 16: two's-complement sample, qualified by sample_valid.
REQ-007 Port i_sample, output, 16: sample to the FFT, registered.
REQ-008 Port i_ce, output, 1: FFT clock enable, registered.
REQ-009 Port o_sync, input, 1: FFT first-output-bin marker, meaningful only in cycles where i_ce=1.
REQ-010 Port td_enable, output, 1: tone detector enable, registered.
REQ-011 Port done, input, 1: tone detector completion, level.
REQ-012 Port Tone, input, 16: tone detector result, valid while done=1.
REQ-013 Port result_ack, input, 1: one-cycle pulse that clears result_valid, overrun and timeout.
REQ-014 Port results, output, 16: latched Tone value.
REQ-015 Port asic_status, output, 8: bit0 busy, bit1 result_valid, bit2 overrun, bit3 timeout, bits7:4 state code; all other bits 0.

Function
REQ-016 The FSM SHALL have exactly these states and codes: IDLE=0, LOAD=1, FLUSH=2, DRAIN=3, DETECT=4, REPORT=5.
REQ-017 IDLE with sample_valid=1 SHALL go to LOAD, count that sample as sample 0 and set sample_cnt=1.
REQ-018 Every accepted sample SHALL produce i_ce=1 for exactly one cycle, in the cycle after sample_valid, with i_sample=sample_in (1-cycle latency).
REQ-019 In LOAD, each sample_valid SHALL increment sample_cnt; acceptance of sample FFT_LEN-1 SHALL transition to FLUSH and clear the counters.
REQ-020 FLUSH: i_ce=1 every cycle, i_sample=0.
REQ-021 FLUSH: a cycle with i_ce=1 and o_sync=1 SHALL transition to DRAIN and set bin_cnt=1 (that sync cycle is bin 0).
REQ-022 FLUSH: if o_sync is not seen within WAIT_MAX cycles, the block SHALL set timeout and return to IDLE.
REQ-023 DRAIN: i_ce=1 and td_enable=1 every cycle, i_sample=0, bin_cnt increments each cycle; td_enable SHALL also be 1 in the sync cycle.
REQ-024 DRAIN: after FFT_LEN bins in total, td_enable and i_ce SHALL drop together and the FSM SHALL enter DETECT.
REQ-025 DETECT: i_ce=0, td_enable=0; done=1 SHALL go to REPORT.
REQ-026 DETECT: if done is not seen within WAIT_MAX cycles, the block SHALL set timeout and go to IDLE with results unchanged.
REQ-027 REPORT, one cycle: results<=Tone and result_valid<=1, then go to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 sample_valid in FLUSH, DRAIN, DETECT or REPORT SHALL set overrun sticky, drop the sample and generate no i_ce for it.
REQ-030 result_ack SHALL clear result_valid, overrun and timeout in the next cycle.
REQ-031 If result_ack and a setting event occur in the same cycle, the set SHALL win.
REQ-032 A new frame SHALL overwrite results even when result_valid=1; overrun SHALL NOT be set in that case.
REQ-033 The timeout counter SHALL saturate and SHALL reload to 0 on every state change.

Reset
REQ-034 reset_n=0 SHALL asynchronously force state=IDLE, all counters to 0, i_ce=0, td_enable=0, i_sample=0, results=0 and asic_status=0x00.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no partial result and no status bit set.
REQ-036 After reset_n rises, the first sample_valid SHALL start a fresh frame at sample 0.

Verification
REQ-037 FFT_LEN=8: 8 sample_valid pulses of values 1..8 -> i_ce pulses carry 1..8 one cycle late, then state=2 with i_sample=0.
REQ-038 o_sync after 3 flush cycles -> exactly 8 cycles of td_enable=1; done with Tone=0x0031 -> results=0x0031 and asic_status bit1=1 one cycle after REPORT.
REQ-039 sample_valid during DRAIN -> asic_status bit2=1, no extra i_ce, bin count still 8; result_ack -> bits 1 and 2 clear.
REQ-040 WAIT_MAX=15, o_sync held 0 -> return to IDLE after 15 FLUSH cycles with asic_status=0x08.
REQ-041 reset_n pulsed low for 1 cycle at sample 4 of LOAD -> all outputs 0 immediately; a new frame then completes normally.
REQ-042 result_ack coincident with the REPORT cycle -> result_valid=1 (set wins).

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Frames MCU samples into a streaming FFT and hands the output bins to a
//   tone detector, then latches the detector result for the host.
//   Frame flow: IDLE -> LOAD (FFT_LEN samples) -> FLUSH (zero-stuff until the
//   FFT raises o_sync) -> DRAIN (FFT_LEN bins with td_enable) -> DETECT (wait
//   for done) -> REPORT (latch Tone) -> IDLE.
//
// Ports
//   clk          : single clock, rising edge
//   reset_n      : asynchronous active-low reset
//   sample_valid : one-cycle pulse, new sample on sample_in
//   sample_in    : 16-bit two's-complement sample
//   i_sample     : registered sample to the FFT
//   i_ce         : registered FFT clock enable
//   o_sync       : FFT first-bin marker, qualified by i_ce
//   td_enable    : registered tone detector enable
//   done         : tone detector completion (level)
//   Tone         : tone detector result, valid while done=1
//   result_ack   : one-cycle pulse, clears result_valid/overrun/timeout
//   results      : latched Tone value
//   asic_status  : {state[3:0], timeout, overrun, result_valid, busy}
module fft_frame_sequencer #(
  parameter int FFT_LEN  = 64,
  parameter int WAIT_MAX = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [15:0] sample_in,
  output logic [15:0] i_sample,
  output logic        i_ce,
  input  logic        o_sync,
  output logic        td_enable,
  input  logic        done,
  input  logic [15:0] Tone,
  input  logic        result_ack,
  output logic [15:0] results,
  output logic [7:0]  asic_status
);

  localparam int DATA_W = 16;
  localparam int SCNT_W = $clog2(FFT_LEN);
  localparam int BCNT_W = $clog2(FFT_LEN + 1);
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(FFT_LEN - 1);
  localparam logic [BCNT_W-1:0] LAST_BIN    = BCNT_W'(FFT_LEN);
  localparam logic [WCNT_W-1:0] WAIT_LAST   = WCNT_W'(WAIT_MAX - 1);
  localparam logic [WCNT_W-1:0] WAIT_SAT    = WCNT_W'(WAIT_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FLUSH  = 3'd2,
    DRAIN  = 3'd3,
    DETECT = 3'd4,
    REPORT = 3'd5
  } stateT;

  stateT                     state;
  logic [SCNT_W-1:0]         sampleCnt;
  logic [BCNT_W-1:0]         binCnt;
  logic [WCNT_W-1:0]         waitCnt;
  logic signed [DATA_W-1:0]  sample_p1;
  logic                      vld_p1;
  logic                      tdEn;
  logic                      resultValid;
  logic                      overrun;
  logic                      timeoutFlag;
  logic [DATA_W-1:0]         resultReg;

  assign i_sample    = sample_p1;
  assign i_ce        = vld_p1;
  assign td_enable   = tdEn;
  assign results     = resultReg;
  assign asic_status = {1'b0, state, timeoutFlag, overrun, resultValid,
                        (state != IDLE)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sampleCnt   <= '0;
      binCnt      <= '0;
      waitCnt     <= '0;
      sample_p1   <= '0;
      vld_p1      <= 1'b0;
      tdEn        <= 1'b0;
      resultValid <= 1'b0;
      overrun     <= 1'b0;
      timeoutFlag <= 1'b0;
      resultReg   <= '0;
    end else begin
      // Stage p0 -> p1: sample/enable to the FFT, one cycle after acceptance.
      vld_p1    <= 1'b0;
      sample_p1 <= '0;

      // Saturating wait counter; every state change below reloads it to 0.
      if (waitCnt != WAIT_SAT) begin
        waitCnt <= waitCnt + 1'b1;
      end

      // Clears first so that any set later in this block takes priority.
      if (result_ack) begin
        resultValid <= 1'b0;
        overrun     <= 1'b0;
        timeoutFlag <= 1'b0;
      end

      // Samples arriving outside IDLE/LOAD are dropped and flagged.
      if (sample_valid && (state != IDLE) && (state != LOAD)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          tdEn <= 1'b0;
          if (sample_valid) begin
            state     <= LOAD;
            sampleCnt <= SCNT_W'(1);
            binCnt    <= '0;
            waitCnt   <= '0;
            vld_p1    <= 1'b1;
            sample_p1 <= $signed(sample_in);
          end
        end

        LOAD: begin
          if (sample_valid) begin
            vld_p1    <= 1'b1;
            sample_p1 <= $signed(sample_in);
            if (sampleCnt == LAST_SAMPLE) begin
              state     <= FLUSH;
              sampleCnt <= '0;
              binCnt    <= '0;
              waitCnt   <= '0;
            end else begin
              sampleCnt <= sampleCnt + 1'b1;
            end
          end
        end

        FLUSH: begin
          // o_sync only counts in a cycle where the FFT is being clocked.
          if (vld_p1 && o_sync) begin
            state   <= DRAIN;
            binCnt  <= BCNT_W'(1);
            waitCnt <= '0;
            vld_p1  <= 1'b1;
            tdEn    <= 1'b1;
          end else if (waitCnt == WAIT_LAST) begin
            state       <= IDLE;
            waitCnt     <= '0;
            timeoutFlag <= 1'b1;
          end else begin
            vld_p1 <= 1'b1;
          end
        end

        DRAIN: begin
          // td_enable spans exactly FFT_LEN cycles: binCnt runs 1..FFT_LEN.
          if (binCnt == LAST_BIN) begin
            state   <= DETECT;
            waitCnt <= '0;
            tdEn    <= 1'b0;
          end else begin
            binCnt <= binCnt + 1'b1;
            vld_p1 <= 1'b1;
            tdEn   <= 1'b1;
          end
        end

        DETECT: begin
          if (done) begin
            state   <= REPORT;
            waitCnt <= '0;
          end else if (waitCnt == WAIT_LAST) begin
            state       <= IDLE;
            waitCnt     <= '0;
            timeoutFlag <= 1'b1;
          end
        end

        REPORT: begin
          resultReg   <= Tone;
          resultValid <= 1'b1;
          state       <= IDLE;
          waitCnt     <= '0;
        end

        default: begin
          state   <= IDLE;
          waitCnt <= '0;
          tdEn    <= 1'b0;
        end
      endcase
    end
  end

endmodule
